shift_deserializer: RTL and testbench
=====================================

// Module: shift_deserializer
// PURPOSE
//  Receive end of the shift-register serial link: collects a framed serial bit stream into WIDTH-bit words.
//  Each completed word is presented on a parallel output with a valid/ready handshake.
//  Sits between the serial link pin logic and parallel consumers of universal shift register data.
//  Holds one output word; a word that completes while that slot is full is dropped and flagged.
// PARAMETERS
//  WIDTH      4  word width in bits; legal range >= 2
//  MSB_FIRST  1  1: first received bit lands in p_out[WIDTH-1]; 0: first received bit lands in p_out[0]
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  sin          in   1      serial data bit
//  sin_valid    in   1      sin is sampled this cycle
//  sin_sof      in   1      start of frame; qualified by sin_valid; marks the first bit of a word
//  p_out        out  WIDTH  assembled word; stable while p_valid=1
//  p_valid      out  1      p_out holds an unconsumed word
//  p_ready      in   1      consumer accepts p_out when p_valid && p_ready
//  busy         out  1      a word is partially received (state SHIFT)
//  frame_err    out  1      one-cycle pulse: sof arrived mid-word
//  overrun      out  1      sticky: a completed word was dropped
//  clr_overrun  in   1      synchronous clear of overrun
// BEHAVIOUR
//  Reset values: p_out=0, p_valid=0, busy=0, frame_err=0, overrun=0, shift reg=0, bit count=0, state IDLE.
//  Async reset mid-word discards the partial word and any held output word.
//  FSM states:
//   IDLE:  bits with sin_valid && !sin_sof are ignored.
//          sin_valid && sin_sof -> shift sin in, cnt=1, go SHIFT.
//   SHIFT: each sin_valid && !sin_sof bit -> shift in, cnt++.
//          sin_valid && sin_sof -> frame_err pulses next cycle; partial word is discarded;
//          this bit becomes bit 0 of a new word with cnt=1; stay SHIFT.
//   Completion: the bit that brings cnt to WIDTH completes the word; go IDLE; cnt=0.
//   Cycles with sin_valid=0 leave the shift reg and cnt unchanged (gaps allowed).
//  Shift rule:
//   MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], sin}.
//   MSB_FIRST=0: sreg <= {sin, sreg[WIDTH-1:1]}.
//   The completed word is the post-shift value.
//  Output slot:
//   Completing word is loaded into p_out, and p_valid=1 the next cycle (latency 1 clk after the last bit),
//   if p_valid=0, or if p_valid && p_ready in the same cycle (simultaneous consume + load: new word wins, no bubble).
//   Otherwise the word is dropped, p_out/p_valid are unchanged, and overrun sets.
//   p_valid && p_ready with no completion: p_valid clears next cycle; p_out retains its value.
//  overrun stays set until clr_overrun=1.
//   If clr_overrun and a new overrun event occur in the same cycle, set wins.
//  frame_err: registered; one cycle high per mid-word sof; never set in IDLE.
//  busy = (state==SHIFT); p_out is never modified while p_valid=1 except via the consume+load case.
// STRUCTURE
//  Shared package shift_pkg:
//   - state typedef {IDLE, SHIFT}
//   - localparams MODE_MSB_FIRST=1, MODE_LSB_FIRST=0
//   - also used by the parallel-to-serial sender
//  One sub-module: shift_bit_counter (WIDTH param).
//   - inputs: inc, restart
//   - output: last (next inc completes a word)
//   - cnt width is $clog2(WIDTH+1)
//  FSM, shift reg and output slot live in the top.
// TESTING
//  1 Reset: assert rst mid-run -> all outputs 0 within the same cycle; first later sof starts a clean word.
//  2 MSB_FIRST=1, WIDTH=4, bits 1,0,1,1 (sof on first), p_ready=1 -> p_out=4'b1011, p_valid=1 one clk after the 4th bit.
//  3 MSB_FIRST=0, same bits -> p_out=4'b1101; insert 3 idle cycles between bits -> same result.
//  4 p_ready=0, send two words 1011 then 0110 -> p_out stays 1011 and overrun=1;
//    clr_overrun -> overrun=0.
//    Then with p_ready=1 on the completion cycle of 0110 -> p_out=0110, no overrun.
//  5 sof after 2 bits, then 4 bits 0,0,0,1 -> frame_err one-cycle pulse, p_out=4'b0001, no overrun.
//  6 Bits without sof while IDLE -> ignored, busy=0, p_valid=0.

Source files
------------

// File: rtl/shift_pkg.sv
// shift_pkg: shared types and mode constants for the shift-register serial link
package shift_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int MODE_MSB_FIRST = 1;
  localparam int MODE_LSB_FIRST = 0;
endpackage

// File: rtl/shift_bit_counter.sv
// shift_bit_counter: counts received bits of the current word; restart loads the first bit
module shift_bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic restart,
  output logic last
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0] cnt;
  assign last = (cnt == CW'(WIDTH - 1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (restart) cnt <= CW'(1);
    else if (inc) cnt <= last ? '0 : cnt + CW'(1);
  end
endmodule

// File: rtl/shift_deserializer.sv
// shift_deserializer: collects framed serial bits into WIDTH-bit words behind a one-word valid/ready slot
module shift_deserializer
  import shift_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = MODE_MSB_FIRST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_sof,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  input  logic             clr_overrun
);
  state_t state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_shift, sreg_first;
  logic sof_bit, dat_bit, last, complete, load;
  assign sof_bit  = sin_valid && sin_sof;
  assign dat_bit  = sin_valid && !sin_sof && (state == SHIFT);
  assign complete = dat_bit && last;
  assign load     = complete && (!p_valid || p_ready);
  assign busy     = (state == SHIFT);
  assign sreg_shift = (MSB_FIRST == MODE_MSB_FIRST) ? {sreg[WIDTH-2:0], sin} : {sin, sreg[WIDTH-1:1]};
  // a start bit always begins from a clean register so a discarded partial word cannot leak in
  assign sreg_first = (MSB_FIRST == MODE_MSB_FIRST) ? {{(WIDTH-1){1'b0}}, sin} : {sin, {(WIDTH-1){1'b0}}};
  shift_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (dat_bit),
    .restart (sof_bit),
    .last    (last)
  );
  always_comb begin
    state_nxt = (state == IDLE) ? (sof_bit ? SHIFT : IDLE) : (complete ? IDLE : SHIFT);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg      <= '0;
      p_out     <= '0;
      p_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sreg      <= sof_bit ? sreg_first : dat_bit ? sreg_shift : sreg;
      p_out     <= load ? sreg_shift : p_out;
      p_valid   <= load ? 1'b1 : (p_valid && p_ready) ? 1'b0 : p_valid;
      frame_err <= sof_bit && (state == SHIFT);
      overrun   <= (complete && !load) ? 1'b1 : clr_overrun ? 1'b0 : overrun;
    end
  end
endmodule

// File: tb/tb_shift_deserializer.sv
// tb_shift_deserializer: directed stimulus into MSB-first and LSB-first instances, checked against a word-level model
module tb_shift_deserializer;
  localparam int W = 4;
  logic clk = 0, rst = 1;
  logic sin = 0, sin_valid = 0, sin_sof = 0, p_ready = 1, clr_overrun = 0;
  logic [W-1:0] po_m, po_l;
  logic pv_m, pv_l, busy_m, busy_l, fe_m, fe_l, ov_m, ov_l;
  int checks = 0, errors = 0;

  shift_deserializer #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_sof(sin_sof),
    .p_out(po_m), .p_valid(pv_m), .p_ready(p_ready), .busy(busy_m),
    .frame_err(fe_m), .overrun(ov_m), .clr_overrun(clr_overrun));
  shift_deserializer #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_sof(sin_sof),
    .p_out(po_l), .p_valid(pv_l), .p_ready(p_ready), .busy(busy_l),
    .frame_err(fe_l), .overrun(ov_l), .clr_overrun(clr_overrun));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // word-level model: list of received bits, placed into the word only when it completes
  logic bits [W];
  int n = 0;
  logic [W-1:0] m_pm = 0, m_pl = 0;
  logic m_pv = 0, m_ovr = 0, m_fe = 0;
  bit done;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0; m_pv = 0; m_pm = 0; m_pl = 0; m_ovr = 0; m_fe = 0;
    end else begin
      done = 0;
      m_fe = 0;
      if (sin_valid) begin
        if (sin_sof) begin
          m_fe = (n > 0);
          bits[0] = sin;
          n = 1;
        end else if (n > 0) begin
          bits[n] = sin;
          n++;
          if (n == W) begin done = 1; n = 0; end
        end
      end
      if (clr_overrun) m_ovr = 0;
      if (done) begin
        if (!m_pv || p_ready) begin
          m_pv = 1;
          for (int i = 0; i < W; i++) begin
            m_pm[W-1-i] = bits[i];
            m_pl[i] = bits[i];
          end
        end else m_ovr = 1;
      end else if (m_pv && p_ready) m_pv = 0;
    end
  end

  always @(negedge clk) begin
    chk("pv_m", 32'(pv_m), 32'(m_pv));
    chk("pv_l", 32'(pv_l), 32'(m_pv));
    chk("pout_m", 32'(po_m), 32'(m_pm));
    chk("pout_l", 32'(po_l), 32'(m_pl));
    chk("busy_m", 32'(busy_m), 32'(n > 0));
    chk("busy_l", 32'(busy_l), 32'(n > 0));
    chk("ferr_m", 32'(fe_m), 32'(m_fe));
    chk("ferr_l", 32'(fe_l), 32'(m_fe));
    chk("ovr_m", 32'(ov_m), 32'(m_ovr));
    chk("ovr_l", 32'(ov_l), 32'(m_ovr));
  end

  task automatic idle(input int k);
    sin_valid = 0; sin_sof = 0;
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic b, input logic sof, input int gap);
    sin = b; sin_sof = sof; sin_valid = 1;
    @(posedge clk); #1;
    sin_valid = 0; sin_sof = 0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic word(input logic [W-1:0] w, input int gap);
    for (int i = W - 1; i >= 0; i--) send(w[i], i == W - 1, gap);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    idle(1);
    // reset mid-word
    send(1, 1, 0);
    send(0, 0, 0);
    chk("busy_before_rst", 32'(busy_m), 32'd1);
    rst = 1; #1;
    chk("rst_busy", 32'(busy_m), 32'd0);
    chk("rst_pv", 32'(pv_m | pv_l), 32'd0);
    chk("rst_pout", 32'(po_m | po_l), 32'd0);
    @(posedge clk); #1 rst = 0;
    idle(1);
    // MSB-first and LSB-first of 1,0,1,1
    word(4'b1011, 0);
    chk("w1_pv", 32'(pv_m), 32'd1);
    chk("w1_pm", 32'(po_m), 32'hb);
    chk("w1_pl", 32'(po_l), 32'hd);
    idle(2);
    word(4'b1011, 3);
    chk("w2_pl", 32'(po_l), 32'hd);
    chk("w2_pm", 32'(po_m), 32'hb);
    idle(2);
    // overrun with stalled consumer
    p_ready = 0;
    word(4'b1011, 0);
    word(4'b0110, 0);
    chk("ovr_pm", 32'(po_m), 32'hb);
    chk("ovr_set", 32'(ov_m), 32'd1);
    clr_overrun = 1; @(posedge clk); #1 clr_overrun = 0;
    chk("ovr_clr", 32'(ov_m), 32'd0);
    send(0, 1, 0); send(1, 0, 0); send(1, 0, 0);
    p_ready = 1;
    send(0, 0, 0);
    chk("swap_pm", 32'(po_m), 32'h6);
    chk("swap_pv", 32'(pv_m), 32'd1);
    chk("swap_ovr", 32'(ov_m), 32'd0);
    idle(2);
    // mid-word sof
    send(1, 1, 0); send(1, 0, 0);
    send(0, 1, 0);
    chk("fe_pulse", 32'(fe_m), 32'd1);
    send(0, 0, 0);
    chk("fe_gone", 32'(fe_m), 32'd0);
    send(0, 0, 0); send(1, 0, 0);
    chk("fe_pm", 32'(po_m), 32'h1);
    chk("fe_ovr", 32'(ov_m), 32'd0);
    idle(2);
    // bits without sof in IDLE
    for (int i = 0; i < 6; i++) send(i[0], 0, 0);
    chk("idle_busy", 32'(busy_m), 32'd0);
    chk("idle_pv", 32'(pv_m), 32'd0);
    idle(2);
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
